guess_scorer: RTL and testbench

Scores a submitted four-position colour guess against the secret code and keeps the game status. The block sits directly downstream of the guess-entry stage: it takes the four 3-bit colour registers that stage produces, plus a one-cycle `submit` pulse, and returns the exact-match and colour-only counts. It also tracks the attempt count and raises win/lose for the display and control logic.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/peg_match_finder.sv | 40 ++++
 rtl/guess_scorer.sv | 223 ++++++++++++++++++++++
 tb/tb_guess_scorer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the guess-scoring datapath.
//   COLOR_W          : width of one colour code
//   NUM_POS          : number of peg positions in a code
//   MAX_ATTEMPTS_DEF : default number of guesses per game
//   score_state_t    : scoring sequencer states
//   code_t           : one packed code, position 0 in the low bits
package mm_pkg;

  localparam int COLOR_W          = 3;
  localparam int NUM_POS          = 4;
  localparam int MAX_ATTEMPTS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    EXACT,
    PARTIAL,
    REPORT,
    OVER
  } score_state_t;

  typedef logic [NUM_POS-1:0][COLOR_W-1:0] code_t;

endpackage

// File: rtl/peg_match_finder.sv
// Combinational search for the lowest secret position that holds a given
// colour and has not yet been consumed by an earlier match.
//   color  : guess colour being looked up
//   secret : full secret code, position 0 in the low bits
//   s_used : secret positions already consumed
//   found  : at least one eligible position exists
//   onehot : one-hot index of the lowest eligible position (0 if none)
module peg_match_finder
  import mm_pkg::*;
#(
  parameter int COLOR_W = mm_pkg::COLOR_W
) (
  input  logic [COLOR_W-1:0]              color,
  input  logic [NUM_POS-1:0][COLOR_W-1:0] secret,
  input  logic [NUM_POS-1:0]              s_used,
  output logic                            found,
  output logic [NUM_POS-1:0]              onehot
);

  logic [NUM_POS-1:0] cand;

  always_comb begin
    for (int p = 0; p < NUM_POS; p++) begin
      cand[p] = !s_used[p] && (secret[p] == color);
    end
  end

  // Priority pick: the first candidate seen from position 0 upward wins.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int p = 0; p < NUM_POS; p++) begin
      if (cand[p] && !found) begin
        onehot[p] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_scorer.sv
// Scores a four-position colour guess against the secret code and tracks
// the game status (attempt count, win, lose).
//   clk, rst_n          : clock and asynchronous active-low reset
//   new_game            : pulse; clears all game state, aborts scoring
//   submit              : pulse; score the current guess (IDLE only)
//   guess_0..guess_3    : guess colours, latched on an accepted submit
//   secret_0..secret_3  : secret colours, latched on an accepted submit
//   busy                : a guess is being scored
//   score_valid         : one-cycle pulse when exact/partial update
//   exact, partial      : right-place count and right-colour-only count
//   attempts            : guesses scored in this game
//   win, lose           : sticky game outcome flags
// A score takes one EXACT cycle, one PARTIAL cycle per position and one
// REPORT cycle, giving a six-cycle submit-to-result latency.
module guess_scorer
  import mm_pkg::*;
#(
  parameter int COLOR_W      = mm_pkg::COLOR_W,
  parameter int MAX_ATTEMPTS = MAX_ATTEMPTS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  input  logic               submit,
  input  logic [COLOR_W-1:0] guess_0,
  input  logic [COLOR_W-1:0] guess_1,
  input  logic [COLOR_W-1:0] guess_2,
  input  logic [COLOR_W-1:0] guess_3,
  input  logic [COLOR_W-1:0] secret_0,
  input  logic [COLOR_W-1:0] secret_1,
  input  logic [COLOR_W-1:0] secret_2,
  input  logic [COLOR_W-1:0] secret_3,
  output logic               busy,
  output logic               score_valid,
  output logic [2:0]         exact,
  output logic [2:0]         partial,
  output logic [3:0]         attempts,
  output logic               win,
  output logic               lose
);

  localparam logic [3:0] MAX_A    = 4'(MAX_ATTEMPTS);
  localparam logic [1:0] LAST_IDX = 2'(NUM_POS - 1);
  localparam logic [2:0] ALL_POS  = 3'(NUM_POS);

  logic [NUM_POS-1:0][COLOR_W-1:0] g_in;
  logic [NUM_POS-1:0][COLOR_W-1:0] s_in;

  score_state_t                    state_q,       state_d;
  logic [NUM_POS-1:0][COLOR_W-1:0] g_code_q,      g_code_d;
  logic [NUM_POS-1:0][COLOR_W-1:0] s_code_q,      s_code_d;
  logic [NUM_POS-1:0]              g_used_q,      g_used_d;
  logic [NUM_POS-1:0]              s_used_q,      s_used_d;
  logic [1:0]                      idx_q,         idx_d;
  logic [2:0]                      exact_acc_q,   exact_acc_d;
  logic [2:0]                      partial_acc_q, partial_acc_d;
  logic [2:0]                      exact_q,       exact_d;
  logic [2:0]                      partial_q,     partial_d;
  logic [3:0]                      attempts_q,    attempts_d;
  logic                            win_q,         win_d;
  logic                            lose_q,        lose_d;
  logic                            score_valid_q, score_valid_d;
  logic                            busy_q,        busy_d;

  logic                            pf_found;
  logic [NUM_POS-1:0]              pf_onehot;
  logic [3:0]                      att_inc;

  assign g_in = {guess_3, guess_2, guess_1, guess_0};
  assign s_in = {secret_3, secret_2, secret_1, secret_0};

  // One finder shared by all four PARTIAL cycles; idx_q selects the guess peg.
  peg_match_finder #(
    .COLOR_W (COLOR_W)
  ) u_finder (
    .color  (g_code_q[idx_q]),
    .secret (s_code_q),
    .s_used (s_used_q),
    .found  (pf_found),
    .onehot (pf_onehot)
  );

  // Saturating increment so the attempt count can never wrap.
  assign att_inc = (attempts_q < MAX_A) ? attempts_q + 4'd1 : attempts_q;

  always_comb begin
    state_d       = state_q;
    g_code_d      = g_code_q;
    s_code_d      = s_code_q;
    g_used_d      = g_used_q;
    s_used_d      = s_used_q;
    idx_d         = idx_q;
    exact_acc_d   = exact_acc_q;
    partial_acc_d = partial_acc_q;
    exact_d       = exact_q;
    partial_d     = partial_q;
    attempts_d    = attempts_q;
    win_d         = win_q;
    lose_d        = lose_q;
    score_valid_d = 1'b0;

    if (new_game) begin
      state_d       = IDLE;
      g_used_d      = '0;
      s_used_d      = '0;
      idx_d         = '0;
      exact_acc_d   = '0;
      partial_acc_d = '0;
      exact_d       = '0;
      partial_d     = '0;
      attempts_d    = '0;
      win_d         = 1'b0;
      lose_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (submit && !win_q && !lose_q) begin
            g_code_d      = g_in;
            s_code_d      = s_in;
            g_used_d      = '0;
            s_used_d      = '0;
            idx_d         = '0;
            exact_acc_d   = '0;
            partial_acc_d = '0;
            state_d       = EXACT;
          end
        end

        EXACT: begin
          // Positional matches consume both pegs before any colour search.
          for (int p = 0; p < NUM_POS; p++) begin
            if (g_code_q[p] == s_code_q[p]) begin
              g_used_d[p] = 1'b1;
              s_used_d[p] = 1'b1;
              exact_acc_d = exact_acc_d + 3'd1;
            end
          end
          state_d = PARTIAL;
        end

        PARTIAL: begin
          if (!g_used_q[idx_q] && pf_found) begin
            s_used_d      = s_used_q | pf_onehot;
            partial_acc_d = partial_acc_q + 3'd1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = REPORT;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end

        REPORT: begin
          exact_d       = exact_acc_q;
          partial_d     = partial_acc_q;
          score_valid_d = 1'b1;
          attempts_d    = att_inc;
          if (exact_acc_q == ALL_POS) begin
            win_d = 1'b1;
          end else if (att_inc == MAX_A) begin
            lose_d = 1'b1;
          end
          state_d = (win_d || lose_d) ? OVER : IDLE;
        end

        OVER: begin
          state_d = OVER;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == EXACT) || (state_d == PARTIAL) || (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      g_code_q      <= '0;
      s_code_q      <= '0;
      g_used_q      <= '0;
      s_used_q      <= '0;
      idx_q         <= '0;
      exact_acc_q   <= '0;
      partial_acc_q <= '0;
      exact_q       <= '0;
      partial_q     <= '0;
      attempts_q    <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      score_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      g_code_q      <= g_code_d;
      s_code_q      <= s_code_d;
      g_used_q      <= g_used_d;
      s_used_q      <= s_used_d;
      idx_q         <= idx_d;
      exact_acc_q   <= exact_acc_d;
      partial_acc_q <= partial_acc_d;
      exact_q       <= exact_d;
      partial_q     <= partial_d;
      attempts_q    <= attempts_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      score_valid_q <= score_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign score_valid = score_valid_q;
  assign exact       = exact_q;
  assign partial     = partial_q;
  assign attempts    = attempts_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed game scenarios plus
// randomized games compared against a colour-count reference model.
module tb_guess_scorer;
  import mm_pkg::*;

  localparam int MAXA = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       submit = 1'b0;
  logic [2:0] guess_0 = '0, guess_1 = '0, guess_2 = '0, guess_3 = '0;
  logic [2:0] secret_0 = '0, secret_1 = '0, secret_2 = '0, secret_3 = '0;
  logic       busy, score_valid, win, lose;
  logic [2:0] exact, partial;
  logic [3:0] attempts;

  int checks = 0;
  int errors = 0;

  // Reference game state
  int  cur_s[4];
  int  m_att;
  bit  m_win, m_lose;

  guess_scorer #(.COLOR_W(3), .MAX_ATTEMPTS(MAXA)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .submit(submit),
    .guess_0(guess_0), .guess_1(guess_1), .guess_2(guess_2), .guess_3(guess_3),
    .secret_0(secret_0), .secret_1(secret_1), .secret_2(secret_2), .secret_3(secret_3),
    .busy(busy), .score_valid(score_valid), .exact(exact), .partial(partial),
    .attempts(attempts), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mastermind score from colour histograms: total colour overlap minus exact.
  function automatic void ref_score(input int g0, g1, g2, g3, output int e, output int p);
    int g[4];
    int cs[8];
    int cg[8];
    int tot;
    g = '{g0, g1, g2, g3};
    for (int c = 0; c < 8; c++) begin cs[c] = 0; cg[c] = 0; end
    e = 0;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i] == cur_s[i]) e++;
      cs[cur_s[i]]++;
      cg[g[i]]++;
    end
    for (int c = 0; c < 8; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    p = tot - e;
  endfunction

  function automatic void ref_apply(input int e);
    if (!m_win && !m_lose) begin
      m_att++;
      if (e == 4) m_win = 1'b1;
      else if (m_att == MAXA) m_lose = 1'b1;
    end
  endfunction

  task automatic start_game(input int a, b, c, d);
    cur_s = '{a, b, c, d};
    secret_0 = 3'(a); secret_1 = 3'(b); secret_2 = 3'(c); secret_3 = 3'(d);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_att = 0; m_win = 1'b0; m_lose = 1'b0;
  endtask

  // Accepted submit: checks the six-cycle latency and busy window, then
  // leaves the outputs as sampled in the score_valid cycle.
  task automatic do_submit(input int a, b, c, d);
    int lat;
    int busy_cnt;
    int e, p;
    guess_0 = 3'(a); guess_1 = 3'(b); guess_2 = 3'(c); guess_3 = 3'(d);
    submit = 1'b1;
    tick();
    submit = 1'b0;
    guess_0 = 3'($urandom); guess_1 = 3'($urandom);
    guess_2 = 3'($urandom); guess_3 = 3'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      tick();
      if (score_valid) lat = k;
      else if (busy) busy_cnt++;
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected 6", lat);
    end
    checks++;
    if (busy_cnt != 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_window: busy cycles %0d (busy now %b), expected 6 (0)", busy_cnt, busy);
    end
    ref_score(a, b, c, d, e, p);
    ref_apply(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, score_valid, exact, partial, attempts, win, lose} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b sv=%b ex=%0d pa=%0d att=%0d win=%b lose=%b, expected all 0",
               busy, score_valid, exact, partial, attempts, win, lose);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exact_win();
    int nv;
    start_game(1, 2, 3, 4);
    do_submit(1, 2, 3, 4);
    checks++;
    if (exact !== 3'd4 || partial !== 3'd0 || win !== 1'b1 || attempts !== 4'd1 || lose !== 1'b0) begin
      errors++;
      $display("FAIL exact_win: ex=%0d pa=%0d win=%b att=%0d lose=%b, expected 4 0 1 1 0",
               exact, partial, win, attempts, lose);
    end
    guess_0 = 3'd0;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      if (score_valid || busy) nv++;
      tick();
    end
    checks++;
    if (nv != 0 || attempts !== 4'd1 || win !== 1'b1 || exact !== 3'd4) begin
      errors++;
      $display("FAIL submit_after_win: activity=%0d att=%0d win=%b ex=%0d, expected 0 1 1 4",
               nv, attempts, win, exact);
    end
  endtask

  task automatic test_reverse();
    start_game(1, 2, 3, 4);
    do_submit(4, 3, 2, 1);
    checks++;
    if (exact !== 3'd0 || partial !== 3'd4 || win !== 1'b0 || attempts !== 4'd1) begin
      errors++;
      $display("FAIL reverse: ex=%0d pa=%0d win=%b att=%0d, expected 0 4 0 1", exact, partial, win, attempts);
    end
  endtask

  task automatic test_duplicates();
    start_game(1, 1, 2, 2);
    do_submit(1, 2, 1, 1);
    checks++;
    if (exact !== 3'd1 || partial !== 3'd2 || attempts !== 4'd1) begin
      errors++;
      $display("FAIL duplicates: ex=%0d pa=%0d att=%0d, expected 1 2 1", exact, partial, attempts);
    end
  endtask

  task automatic test_ignored_submit();
    int nv;
    start_game(5, 6, 7, 0);
    guess_0 = 3'd0; guess_1 = 3'd5; guess_2 = 3'd6; guess_3 = 3'd7;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    nv = 0;
    for (int k = 1; k <= 16; k++) begin
      submit = (k == 3);
      tick();
      if (score_valid) nv++;
    end
    submit = 1'b0;
    checks++;
    if (nv != 1 || attempts !== 4'd1 || exact !== 3'd0 || partial !== 3'd4) begin
      errors++;
      $display("FAIL busy_submit_ignored: pulses=%0d att=%0d ex=%0d pa=%0d, expected 1 1 0 4",
               nv, attempts, exact, partial);
    end
  endtask

  task automatic test_lose();
    int nv;
    start_game(0, 0, 0, 0);
    for (int n = 1; n <= MAXA; n++) begin
      do_submit(7, 7, 7, 7);
      checks++;
      if (exact !== 3'd0 || partial !== 3'd0 || attempts !== 4'(n) || lose !== (n == MAXA) || win !== 1'b0) begin
        errors++;
        $display("FAIL lose_seq[%0d]: ex=%0d pa=%0d att=%0d lose=%b win=%b, expected 0 0 %0d %0d 0",
                 n, exact, partial, attempts, lose, win, n, (n == MAXA));
      end
    end
    guess_0 = 3'd0; guess_1 = 3'd0; guess_2 = 3'd0; guess_3 = 3'd0;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      if (score_valid || busy) nv++;
      tick();
    end
    checks++;
    if (nv != 0 || attempts !== 4'd10 || lose !== 1'b1 || win !== 1'b0) begin
      errors++;
      $display("FAIL submit_after_lose: activity=%0d att=%0d lose=%b win=%b, expected 0 10 1 0",
               nv, attempts, lose, win);
    end
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    checks++;
    if ({busy, score_valid, exact, partial, attempts, win, lose} !== 16'h0) begin
      errors++;
      $display("FAIL new_game_clear: ex=%0d pa=%0d att=%0d win=%b lose=%b busy=%b, expected all 0",
               exact, partial, attempts, win, lose, busy);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    start_game(1, 2, 3, 4);
    do_submit(2, 1, 3, 5);
    guess_0 = 3'd1; guess_1 = 3'd1; guess_2 = 3'd1; guess_3 = 3'd1;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, score_valid, exact, partial, attempts, win, lose} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b ex=%0d pa=%0d att=%0d, expected all 0", busy, exact, partial, attempts);
    end
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (score_valid) nv++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (score_valid || busy) nv++;
    end
    checks++;
    if (nv != 0 || attempts !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_no_score: activity=%0d att=%0d, expected 0 0", nv, attempts);
    end
  endtask

  task automatic test_newgame_submit();
    int nv;
    start_game(0, 1, 2, 3);
    do_submit(3, 2, 1, 0);
    checks++;
    if (attempts !== 4'd1 || partial !== 3'd4) begin
      errors++;
      $display("FAIL ng_pre_score: att=%0d pa=%0d, expected 1 4", attempts, partial);
    end
    guess_0 = 3'd0; guess_1 = 3'd1; guess_2 = 3'd2; guess_3 = 3'd3;
    new_game = 1'b1;
    submit = 1'b1;
    tick();
    new_game = 1'b0;
    submit = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      if (score_valid || busy) nv++;
      tick();
    end
    checks++;
    if (nv != 0 || attempts !== 4'd0 || exact !== 3'd0 || partial !== 3'd0 || win !== 1'b0) begin
      errors++;
      $display("FAIL newgame_beats_submit: activity=%0d att=%0d ex=%0d pa=%0d win=%b, expected 0 0 0 0 0",
               nv, attempts, exact, partial, win);
    end
  endtask

  task automatic test_random();
    int g[4];
    int e, p;
    for (int game = 0; game < 40; game++) begin
      start_game($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
      for (int n = 0; n < 4 && !m_win && !m_lose; n++) begin
        if ($urandom_range(0, 4) == 0) g = cur_s;
        else for (int i = 0; i < 4; i++) g[i] = $urandom_range(0, 3);
        ref_score(g[0], g[1], g[2], g[3], e, p);
        do_submit(g[0], g[1], g[2], g[3]);
        checks++;
        if (exact !== 3'(e) || partial !== 3'(p) || attempts !== 4'(m_att) || win !== m_win || lose !== m_lose) begin
          errors++;
          $display("FAIL random[%0d.%0d]: s=%0d%0d%0d%0d g=%0d%0d%0d%0d got ex=%0d pa=%0d att=%0d win=%b lose=%b, expected %0d %0d %0d %b %b",
                   game, n, cur_s[0], cur_s[1], cur_s[2], cur_s[3], g[0], g[1], g[2], g[3],
                   exact, partial, attempts, win, lose, e, p, m_att, m_win, m_lose);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_win();
    test_reverse();
    test_duplicates();
    test_ignored_submit();
    test_lose();
    test_reset_mid();
    test_newgame_submit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
